hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core; drives the 2-bit selects of both EX-stage forwarding mux4s.
//  Detects load-use hazards, redirects on taken branches/jumps and freezes the pipe while data memory is not ready.
//  Holds a small FSM for memory-wait handling, with a timeout that raises a bus error.
// PARAMETERS
//  TIMEOUT_CYC  255  max consecutive MEM_WAIT cycles before mem_err; 0 disables the timeout
//  CNT_W        32   width of optional performance counters
// PORTS
//  clk            in   1   core clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  Rs1D,Rs2D      in   5   source regs in ID
//  Rs1E,Rs2E,RdE  in   5   source/dest regs in EX
//  ResultSrcE     in   2   00 ALU, 01 load, 10 PC+4
//  RdM,RdW        in   5   dest regs in MEM / WB
//  RegWriteM      in   1   MEM instr writes RdM
//  RegWriteW      in   1   WB instr writes RdW
//  ResultSrcM     in   2   encoding as ResultSrcE
//  PCSrcE         in   1   taken branch/jump resolved in EX
//  MemReqM        in   1   load/store active in MEM
//  dmem_ready     in   1   data memory completes access this cycle
//  ForwardAE      out  2   00 RD1E, 01 ResultW, 10 ALUResultM, 11 PCPlus4M
//  ForwardBE      out  2   same encoding for RD2E
//  StallF,StallD  out  1   hold PC / IF-ID register
//  StallE,StallM  out  1   hold ID-EX / EX-MEM register
//  FlushD,FlushE  out  1   bubble IF-ID / ID-EX
//  FlushW         out  1   bubble MEM-WB
//  mem_err        out  1   one-cycle pulse on memory timeout
// BEHAVIOUR
//  Forwarding (combinational, same cycle): for RsxE!=0, MEM beats WB:
//   RegWriteM & RdM==RsxE: ResultSrcM==10 -> 11, else -> 10; else RegWriteW & RdW==RsxE -> 01; else 00.
//  Load-use (combinational, RUN only): ResultSrcE==01 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE)
//   -> StallF=StallD=1, FlushE=1.
//  Redirect (RUN only): PCSrcE -> FlushD=FlushE=1; takes priority over load-use stalls.
//  FSM states RUN, MEM_WAIT, MEM_ERR; reset -> RUN, wait counter 0.
//   RUN: MemReqM & !dmem_ready -> MEM_WAIT, freezing the pipe that cycle; otherwise stay.
//   MEM_WAIT: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//    dmem_ready -> RUN; freeze is released the same cycle dmem_ready is seen.
//    Wait counter reaches TIMEOUT_CYC -> MEM_ERR.
//    Wait counter saturates; it is cleared on leaving MEM_WAIT.
//   MEM_ERR: mem_err=1 and FlushW=1 for one cycle, stalls released, -> RUN.
//  Taken branch held in EX during a wait: redirect is deferred until the first RUN cycle; PCSrcE stays valid because EX is stalled.
//  Reset values: all stalls/flushes/mem_err 0, ForwardAE/BE 00. rst_n low mid-wait aborts to RUN immediately.
//  x0 is never forwarded and never causes a load-use stall.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt, flush_cnt, wait_cnt [CNT_W-1:0].
//   Counts load-use stalls, redirects and MEM_WAIT cycles; counters wrap and are reset to 0.
//  Not defined: no counter logic and no extra ports.
// STRUCTURE
//  hazard_pkg: fwd_sel_e (FWD_RF, FWD_WB, FWD_ALUM, FWD_PC4M), result_src_e, hz_state_e.
//  Sub-module fwd_sel: one source compare -> fwd_sel_e; instantiated twice (A, B).
// TESTING
//  1 Back-to-back add x5 followed by a read of x5 in EX (RegWriteM=1, RdM=5, Rs1E=5) -> ForwardAE=10.
//  2 jal x1 in MEM (ResultSrcM=10, RdM=1) with Rs2E=1 -> ForwardBE=11.
//    Same instr in WB only -> 01.
//  3 lw x7 in EX, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle.
//    Same with RdE=0 -> no stall.
//  4 MemReqM=1, dmem_ready low 3 cycles -> all stalls+FlushW high 3 cycles, low on cycle 4, state RUN.
//  5 TIMEOUT_CYC=4, dmem_ready never rises -> mem_err pulses once on cycle 5, then RUN.
//  6 PCSrcE=1 during MEM_WAIT -> FlushD/E stay 0 until wait ends, then pulse 1 cycle.
//    Also assert rst_n low mid-wait -> outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, result sources, FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_ALUM = 2'b10,
    FWD_PC4M = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  typedef logic [1:0] hz_state_e;

  localparam hz_state_e HZ_RUN      = 2'd0;
  localparam hz_state_e HZ_MEM_WAIT = 2'd1;
  localparam hz_state_e HZ_MEM_ERR  = 2'd2;

  // Wait counter width; with the timeout disabled it only needs to saturate.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    if (timeout == 0) begin
      return 8;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX source operand; a MEM-stage producer beats a WB-stage one.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [1:0] result_src_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (reg_write_m && (rd_m == rs)) begin
        // A jal/jalr in MEM has no ALU result worth forwarding, only its link value.
        sel = (result_src_m == RES_PC4) ? FWD_PC4M : FWD_ALUM;
      end else if (reg_write_w && (rd_w == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core: forwarding, load-use stalls, redirects, memory wait.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/wait performance counter outputs.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcM,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int unsigned WaitW = wait_cnt_width(TIMEOUT_CYC);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT_CYC);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  logic             freeze, err_cycle;
  logic             run_ok, load_use, redirect, stall_lu;
  fwd_sel_e         fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .result_src_m(ResultSrcM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .result_src_m(ResultSrcM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign wait_inc = (wait_q == '1) ? wait_q : wait_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    freeze    = 1'b0;
    err_cycle = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (MemReqM && !dmem_ready) begin
          freeze  = 1'b1;
          wait_d  = wait_inc;
          state_d = HZ_MEM_WAIT;
        end
      end
      HZ_MEM_WAIT: begin
        if (dmem_ready) begin
          wait_d  = '0;
          state_d = HZ_RUN;
        end else begin
          freeze = 1'b1;
          wait_d = wait_inc;
          if ((TIMEOUT_CYC != 0) && (wait_inc >= TimeoutVal)) begin
            wait_d  = '0;
            state_d = HZ_MEM_ERR;
          end
        end
      end
      HZ_MEM_ERR: begin
        err_cycle = 1'b1;
        wait_d    = '0;
        state_d   = HZ_RUN;
      end
      default: begin
        wait_d  = '0;
        state_d = HZ_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Redirect and load-use only act in a normal RUN cycle; a branch held in EX
  // during a wait is picked up on the first RUN cycle after it.
  assign run_ok   = (state_q == HZ_RUN) && !freeze;
  assign load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));
  assign redirect = run_ok && PCSrcE;
  assign stall_lu = run_ok && load_use && !redirect;

  // Gating with rst_n keeps every output quiet while reset is held, whatever the inputs do.
  assign ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign ForwardBE = rst_n ? fwd_b : FWD_RF;
  assign StallF    = rst_n && (freeze || stall_lu);
  assign StallD    = rst_n && (freeze || stall_lu);
  assign StallE    = rst_n && freeze;
  assign StallM    = rst_n && freeze;
  assign FlushD    = rst_n && redirect;
  assign FlushE    = rst_n && (redirect || stall_lu);
  assign FlushW    = rst_n && (freeze || err_cycle);
  assign mem_err   = rst_n && err_cycle;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_lu) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (state_q == HZ_MEM_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
